// File: rtl/if_fetch_if.sv
// Purpose : fetch-stage signal bundle: redirect inputs, instruction-memory
//           request/response channel and the decode-side instruction channel.
// Modports: master = fetch unit (drives imem request and instruction output),
//           slave  = surrounding environment (redirects, memory, decode).
interface if_fetch_if #(
  parameter int XLEN = 64
);
  // redirect sources
  logic            exc_valid;
  logic [XLEN-1:0] exc_pc;
  logic            ctl_valid;
  logic [XLEN-1:0] ctl_pc;
  // instruction memory request / response
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  // decode channel
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_pc;
  logic [31:0]     inst;

  modport master (
    input  exc_valid, exc_pc, ctl_valid, ctl_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst_valid, inst_pc, inst,
    input  inst_ready
  );

  modport slave (
    output exc_valid, exc_pc, ctl_valid, ctl_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst_valid, inst_pc, inst,
    output inst_ready
  );
endinterface

// File: rtl/if_fetch.sv
// Purpose : instruction fetch front end; owns the fetch PC, issues one imem read at a time.
// Latency : request at t, response at t+k, instruction presented to decode at t+k+1.
// Backpressure: no new request while the one-entry output register is full and not being drained.
// Ports   : clock, reset (async active-low); bus (if_fetch_if.master) carries
//           redirects, imem request/response and the {pc, inst} decode channel.
module if_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic       clock,
  input  logic       reset,
  if_fetch_if.master bus
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic            r_inst_valid;
  logic [XLEN-1:0] r_inst_pc;
  logic [31:0]     r_inst;

  logic            w_redir;
  logic [XLEN-1:0] w_target;
  logic            w_space;
  logic            w_req_vld;
  logic            w_req_fire;
  logic            w_consume;

  // Exception wins over control transfer; targets are forced word aligned.
  assign w_redir  = bus.exc_valid | bus.ctl_valid;
  assign w_target = (bus.exc_valid ? bus.exc_pc : bus.ctl_pc) & ~XLEN'(3);

  assign w_space   = !r_inst_valid | bus.inst_ready;
  // Gated by reset so nothing is requested while reset is held.
  assign w_req_vld = reset & (r_state == S_REQ) & w_space & !w_redir;
  assign w_req_fire = w_req_vld & bus.imem_req_ready;
  assign w_consume  = r_inst_valid & bus.inst_ready;

  assign bus.imem_req_valid = w_req_vld;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.inst_valid     = r_inst_valid;
  assign bus.inst_pc        = r_inst_pc;
  assign bus.inst           = r_inst;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_REQ;
      r_fetch_pc   <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_inst_pc    <= '0;
      r_inst       <= '0;
    end else if (w_redir) begin
      // Redirect flushes the output register regardless of inst_ready.
      r_fetch_pc   <= w_target;
      r_inst_valid <= 1'b0;
      case (r_state)
        // A response arriving with the redirect is the stale one: drop it
        // and fetch the target next. Otherwise wait for it in DRAIN.
        // In DRAIN the stale response still retires the outstanding read,
        // so leaving DRAIN on it avoids waiting for a response that never comes.
        S_WAIT,
        S_DRAIN: r_state <= bus.imem_resp_valid ? S_REQ : S_DRAIN;
        default: r_state <= S_REQ;
      endcase
    end else begin
      if (w_consume) begin
        r_inst_valid <= 1'b0;
      end
      case (r_state)
        S_REQ: begin
          if (w_req_fire) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Output register is known empty here: requests only issue with space.
          if (bus.imem_resp_valid) begin
            r_inst_valid <= 1'b1;
            r_inst_pc    <= r_fetch_pc;
            r_inst       <= bus.imem_resp_data;
            r_fetch_pc   <= r_fetch_pc + XLEN'(4);
            r_state      <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (bus.imem_resp_valid) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Purpose : self-checking bench for if_fetch: directed cycle table plus
//           randomized traffic against a transaction-level reference model.
// Ports   : none (top level); drives the slave side of if_fetch_if.
module tb_if_fetch;

  localparam logic [63:0] B   = 64'h8000_0000;
  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  if_fetch_if #(.XLEN(64)) bus ();

  if_fetch #(.XLEN(64), .RESET_PC(64'h8000_0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic        ir;
    logic        ev;
    logic [63:0] epc;
    logic        cv;
    logic [63:0] cpc;
    logic        x_rv;
    logic [63:0] x_addr;
    logic        x_iv;
    logic [63:0] x_ipc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] dword(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  function automatic vec_t mk(input logic rdy, input logic rv, input logic ir,
                              input logic ev, input logic [63:0] epc,
                              input logic cv, input logic [63:0] cpc,
                              input logic x_rv, input logic [63:0] x_addr,
                              input logic x_iv, input logic [63:0] x_ipc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.ir = ir; v.ev = ev; v.epc = epc;
    v.cv = cv; v.cpc = cpc; v.x_rv = x_rv; v.x_addr = x_addr;
    v.x_iv = x_iv; v.x_ipc = x_ipc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.exc_valid       = 1'b0;
    bus.exc_pc          = '0;
    bus.ctl_valid       = 1'b0;
    bus.ctl_pc          = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.inst_ready      = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req_valid"}, 64'(bus.imem_req_valid), 64'd0);
    chk({tag, "_req_addr"},  bus.imem_req_addr, B);
    chk({tag, "_inst_valid"}, 64'(bus.inst_valid), 64'd0);
    chk({tag, "_inst_pc"},   bus.inst_pc, 64'd0);
    chk({tag, "_inst"},      64'(bus.inst), 64'd0);
  endtask

  // Hold reset for a few cycles, check reset outputs, release at a falling edge.
  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clock);
    #1;
    check_reset_state(tag);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Reference model state (transaction level)
  logic [63:0] m_pc;
  logic        m_out, m_stale, m_has;
  logic [63:0] m_opc;
  logic [31:0] m_oinst;
  logic        mem_pend;
  int          mem_cnt;

  function automatic logic [63:0] rand_pc();
    if ($urandom_range(3) == 0) return 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(255));
    return B + 64'($urandom_range(4095));
  endfunction

  initial begin
    // ---------------- directed cycle table ----------------
    tbl.push_back(mk(1,0,1, 0,0,0,0,     1,B,       0,0));        // 0 first request
    tbl.push_back(mk(1,1,1, 0,0,0,0,     0,B,       0,0));        // 1 k=1 response
    tbl.push_back(mk(1,0,1, 0,0,0,0,     1,B+4,     1,B));        // 2
    tbl.push_back(mk(1,1,1, 0,0,0,0,     0,B+4,     0,0));        // 3
    tbl.push_back(mk(1,0,1, 0,0,0,0,     1,B+8,     1,B+4));      // 4
    tbl.push_back(mk(1,1,1, 0,0,0,0,     0,B+8,     0,0));        // 5
    for (int k = 0; k < 5; k++)                                    // 6..10 decode stalls
      tbl.push_back(mk(1,0,0, 0,0,0,0,   0,B+12,    1,B+8));
    tbl.push_back(mk(1,0,1, 0,0,0,0,     1,B+12,    1,B+8));      // 11 stall released
    tbl.push_back(mk(1,1,1, 0,0,0,0,     0,B+12,    0,0));        // 12
    tbl.push_back(mk(1,0,1, 0,0,0,0,     1,B+16,    1,B+12));     // 13
    tbl.push_back(mk(1,0,1, 0,0,1,B+'h100, 0,B+16,  0,0));        // 14 ctl redirect in WAIT
    tbl.push_back(mk(1,0,1, 0,0,0,0,     0,B+'h100, 0,0));        // 15 draining
    tbl.push_back(mk(1,0,1, 0,0,0,0,     0,B+'h100, 0,0));        // 16
    tbl.push_back(mk(1,1,1, 0,0,0,0,     0,B+'h100, 0,0));        // 17 stale response
    tbl.push_back(mk(1,0,1, 0,0,0,0,     1,B+'h100, 0,0));        // 18 fetch target
    tbl.push_back(mk(1,1,1, 1,B+'h200,1,B+'h300, 0,B+'h100, 0,0)); // 19 exc+ctl+resp
    tbl.push_back(mk(0,0,1, 0,0,0,0,     1,B+'h200, 0,0));        // 20 exc target wins
    tbl.push_back(mk(1,0,1, 0,0,1,B+'h103, 0,B+'h200, 0,0));      // 21 unaligned target
    tbl.push_back(mk(1,0,1, 0,0,0,0,     1,B+'h100, 0,0));        // 22
    tbl.push_back(mk(1,1,1, 0,0,0,0,     0,B+'h100, 0,0));        // 23
    tbl.push_back(mk(0,0,1, 0,0,0,0,     1,B+'h104, 1,B+'h100));  // 24
    tbl.push_back(mk(0,0,1, 0,0,1,TOP,   0,B+'h104, 0,0));        // 25 redirect to top
    tbl.push_back(mk(1,0,1, 0,0,0,0,     1,TOP,     0,0));        // 26
    tbl.push_back(mk(1,1,1, 0,0,0,0,     0,TOP,     0,0));        // 27
    tbl.push_back(mk(0,0,0, 0,0,0,0,     0,64'd0,   1,TOP));      // 28 wrapped PC
    tbl.push_back(mk(0,0,0, 0,0,0,0,     0,64'd0,   1,TOP));      // 29
    tbl.push_back(mk(0,0,1, 0,0,1,B,     0,64'd0,   1,TOP));      // 30 flush with inst_ready
    tbl.push_back(mk(0,0,1, 0,0,0,0,     1,B,       0,0));        // 31

    idle_inputs();
    do_reset("rst0");

    foreach (tbl[i]) begin
      @(negedge clock);
      bus.imem_req_ready  = tbl[i].rdy;
      bus.imem_resp_valid = tbl[i].rv;
      bus.imem_resp_data  = dword(tbl[i].x_addr);
      bus.inst_ready      = tbl[i].ir;
      bus.exc_valid       = tbl[i].ev;
      bus.exc_pc          = tbl[i].epc;
      bus.ctl_valid       = tbl[i].cv;
      bus.ctl_pc          = tbl[i].cpc;
      #1;
      chk($sformatf("tv%0d_req_valid", i), 64'(bus.imem_req_valid), 64'(tbl[i].x_rv));
      chk($sformatf("tv%0d_req_addr", i), bus.imem_req_addr, tbl[i].x_addr);
      chk($sformatf("tv%0d_inst_valid", i), 64'(bus.inst_valid), 64'(tbl[i].x_iv));
      if (tbl[i].x_iv) begin
        chk($sformatf("tv%0d_inst_pc", i), bus.inst_pc, tbl[i].x_ipc);
        chk($sformatf("tv%0d_inst", i), 64'(bus.inst), 64'(dword(tbl[i].x_ipc)));
      end
    end

    // ---------------- randomized traffic vs reference model ----------------
    do_reset("rst1");
    m_pc = B; m_out = 0; m_stale = 0; m_has = 0; m_opc = '0; m_oinst = '0;
    mem_pend = 0; mem_cnt = 0;

    for (int c = 0; c < 3000; c++) begin
      logic        ev, cv, redir, x_rv, resp, ir, rdy, fire;
      logic [63:0] tgt;
      logic [31:0] data;
      @(negedge clock);
      resp = mem_pend && (mem_cnt == 0);
      data = $urandom;
      rdy  = ($urandom_range(9) < 6);
      ir   = ($urandom_range(9) < 7);
      ev   = ($urandom_range(19) == 0);
      cv   = ($urandom_range(14) == 0);
      bus.imem_resp_valid = resp;
      bus.imem_resp_data  = data;
      bus.imem_req_ready  = rdy;
      bus.inst_ready      = ir;
      bus.exc_valid       = ev;
      bus.exc_pc          = rand_pc();
      bus.ctl_valid       = cv;
      bus.ctl_pc          = rand_pc();
      #1;
      redir = ev | cv;
      tgt   = (ev ? bus.exc_pc : bus.ctl_pc) & ~64'd3;
      // A request may go out only with nothing outstanding, room downstream, no redirect.
      x_rv  = !m_out && (!m_has || ir) && !redir;

      chk($sformatf("rnd%0d_req_valid", c), 64'(bus.imem_req_valid), 64'(x_rv));
      chk($sformatf("rnd%0d_req_addr", c), bus.imem_req_addr, m_pc);
      chk($sformatf("rnd%0d_inst_valid", c), 64'(bus.inst_valid), 64'(m_has));
      if (m_has) begin
        chk($sformatf("rnd%0d_inst_pc", c), bus.inst_pc, m_opc);
        chk($sformatf("rnd%0d_inst", c), 64'(bus.inst), 64'(m_oinst));
      end

      fire = bus.imem_req_valid & rdy;

      // model step at the clock edge
      if (redir) begin
        m_has = 0;
        m_pc  = tgt;
        if (m_out) begin
          if (resp) begin m_out = 0; m_stale = 0; end
          else m_stale = 1;
        end
      end else begin
        if (m_has && ir) m_has = 0;
        if (resp) begin
          m_out = 0;
          if (!m_stale) begin
            m_has = 1; m_opc = m_pc; m_oinst = data; m_pc = m_pc + 64'd4;
          end
          m_stale = 0;
        end
        if (x_rv && rdy) m_out = 1;
      end

      // memory: one response, 1..4 cycles after acceptance
      if (resp) mem_pend = 0;
      else if (mem_pend) mem_cnt--;
      if (fire) begin
        mem_pend = 1;
        mem_cnt  = $urandom_range(3);
      end
    end

    // ---------------- asynchronous reset mid-transaction ----------------
    @(negedge clock);
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b0;
    bus.exc_valid      = 1'b0;
    bus.ctl_valid      = 1'b0;
    bus.imem_resp_valid = 1'b0;
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("arst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
